// File: rtl/seq_control_unit_if.sv
// Instruction/control bundle between issue logic and seq_control_unit; the DUT side is slave.
// Carries no state, so it adds no latency; stall/flush travel alongside the instruction.
interface seq_control_unit_if #(
  parameter int REG_CNT = 16,
  parameter int OFS_W   = $clog2(REG_CNT) + 2
);
  logic                       valid_in;
  logic [1:0]                 mode;
  logic [3:0]                 op_code;
  logic                       s_in;
  logic                       blk;
  logic [REG_CNT-1:0]         reg_list;
  logic [3:0]                 cond;
  logic [3:0]                 status;
  logic                       stall;
  logic                       flush;

  logic [3:0]                 exe_cmd;
  logic                       mem_r_en;
  logic                       mem_w_en;
  logic                       wb_en;
  logic                       s;
  logic                       b;
  logic                       valid_out;
  logic                       busy;
  logic [$clog2(REG_CNT)-1:0] xfer_reg;
  logic [OFS_W-1:0]           xfer_ofs;

  modport master (
    output valid_in, mode, op_code, s_in, blk, reg_list, cond, status, stall, flush,
    input  exe_cmd, mem_r_en, mem_w_en, wb_en, s, b, valid_out, busy, xfer_reg, xfer_ofs
  );

  modport slave (
    input  valid_in, mode, op_code, s_in, blk, reg_list, cond, status, stall, flush,
    output exe_cmd, mem_r_en, mem_w_en, wb_en, s, b, valid_out, busy, xfer_reg, xfer_ofs
  );
endinterface

// File: rtl/seq_control_unit.sv
// Instruction decode + block-transfer sequencer, 1-cycle latency; busy blocks new instructions, stall holds everything.
// Optional condition-code gating is enabled by the COND_CHECK_EN macro.
module seq_control_unit #(
  parameter int REG_CNT = 16,
  parameter int OFS_W   = $clog2(REG_CNT) + 2
) (
  input  logic              clk,
  input  logic              rst,
  seq_control_unit_if.slave bus
);
  localparam int IDX_W = $clog2(REG_CNT);

  typedef enum logic {IDLE, XFER} state_t;

  state_t             r_state;
  logic [REG_CNT-1:0] r_rem;
  logic [OFS_W-1:0]   r_cnt;
  logic               r_load;

  logic [3:0]         r_exe_cmd;
  logic               r_mem_r_en;
  logic               r_mem_w_en;
  logic               r_wb_en;
  logic               r_s;
  logic               r_b;
  logic               r_valid_out;
  logic [IDX_W-1:0]   r_xfer_reg;
  logic [OFS_W-1:0]   r_xfer_ofs;

  logic               w_cond_ok;
  logic [REG_CNT-1:0] w_list;
  logic [REG_CNT-1:0] w_rest;
  logic [IDX_W-1:0]   w_idx;
  logic [OFS_W-1:0]   w_ofs;
  logic               w_alu_hit;
  logic [3:0]         w_dec_exe;
  logic               w_dec_r;
  logic               w_dec_w;
  logic               w_dec_wb;
  logic               w_dec_s;
  logic               w_dec_b;
  logic               w_dec_blk;
  logic [IDX_W-1:0]   w_dec_reg;

`ifdef COND_CHECK_EN
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = !z;
      4'h2:    cond_pass = cy;
      4'h3:    cond_pass = !cy;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = !n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = !v;
      4'h8:    cond_pass = cy && !z;
      4'h9:    cond_pass = !cy || z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = !z && (n == v);
      4'hD:    cond_pass = z || (n != v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  assign w_cond_ok = cond_pass(bus.cond, bus.status);
`else
  wire w_unused_cond = ^{bus.cond, bus.status};
  assign w_cond_ok = 1'b1;
`endif

  // One priority encoder serves both the first transfer (fresh list) and later ones (remaining list).
  assign w_list = (r_state == XFER) ? r_rem : bus.reg_list;
  assign w_rest = w_list & (w_list - REG_CNT'(1));
  assign w_ofs  = OFS_W'(r_cnt << 2);

  always_comb begin
    w_idx = '0;
    for (int i = REG_CNT - 1; i >= 0; i--) begin
      if (w_list[i]) w_idx = IDX_W'(i);
    end
  end

  always_comb begin
    w_alu_hit = 1'b0;
    w_dec_exe = '0;
    w_dec_r   = 1'b0;
    w_dec_w   = 1'b0;
    w_dec_wb  = 1'b0;
    w_dec_s   = 1'b0;
    w_dec_b   = 1'b0;
    w_dec_blk = 1'b0;
    w_dec_reg = '0;
    if (bus.valid_in && w_cond_ok) begin
      case (bus.mode)
        2'b00: begin
          case (bus.op_code)
            4'b1101: {w_alu_hit, w_dec_exe, w_dec_wb} = 6'b1_0001_1;
            4'b1111: {w_alu_hit, w_dec_exe, w_dec_wb} = 6'b1_1001_1;
            4'b0100: {w_alu_hit, w_dec_exe, w_dec_wb} = 6'b1_0010_1;
            4'b0101: {w_alu_hit, w_dec_exe, w_dec_wb} = 6'b1_0011_1;
            4'b0010: {w_alu_hit, w_dec_exe, w_dec_wb} = 6'b1_0100_1;
            4'b0110: {w_alu_hit, w_dec_exe, w_dec_wb} = 6'b1_0101_1;
            4'b0000: {w_alu_hit, w_dec_exe, w_dec_wb} = 6'b1_0110_1;
            4'b1100: {w_alu_hit, w_dec_exe, w_dec_wb} = 6'b1_0111_1;
            4'b0001: {w_alu_hit, w_dec_exe, w_dec_wb} = 6'b1_1000_1;
            4'b1010: {w_alu_hit, w_dec_exe, w_dec_wb} = 6'b1_0100_0;
            4'b1000: {w_alu_hit, w_dec_exe, w_dec_wb} = 6'b1_0110_0;
            default: {w_alu_hit, w_dec_exe, w_dec_wb} = 6'b0_0000_0;
          endcase
          w_dec_s = w_alu_hit & bus.s_in;
        end
        2'b01: begin
          // An empty block list degenerates to a NOP.
          if (!bus.blk || (bus.reg_list != '0)) begin
            w_dec_exe = 4'b0010;
            w_dec_r   = bus.s_in;
            w_dec_w   = !bus.s_in;
            w_dec_wb  = bus.s_in;
            if (bus.blk) begin
              w_dec_blk = 1'b1;
              w_dec_reg = w_idx;
            end
          end
        end
        2'b10: begin
          w_dec_b = 1'b1;
          w_dec_s = bus.s_in;
        end
        default: ;
      endcase
    end
  end

  // Flush clears exactly the same state as reset, so the two share one branch.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_load      <= 1'b0;
      r_exe_cmd   <= '0;
      r_mem_r_en  <= 1'b0;
      r_mem_w_en  <= 1'b0;
      r_wb_en     <= 1'b0;
      r_s         <= 1'b0;
      r_b         <= 1'b0;
      r_valid_out <= 1'b0;
      r_xfer_reg  <= '0;
      r_xfer_ofs  <= '0;
    end else if (!bus.stall) begin
      case (r_state)
        XFER: begin
          r_valid_out <= 1'b1;
          r_exe_cmd   <= 4'b0010;
          r_mem_r_en  <= r_load;
          r_mem_w_en  <= !r_load;
          r_wb_en     <= r_load;
          r_s         <= 1'b0;
          r_b         <= 1'b0;
          r_xfer_reg  <= w_idx;
          r_xfer_ofs  <= w_ofs;
          r_rem       <= w_rest;
          if (w_rest == '0) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + OFS_W'(1);
          end
        end
        default: begin
          r_valid_out <= bus.valid_in;
          r_exe_cmd   <= w_dec_exe;
          r_mem_r_en  <= w_dec_r;
          r_mem_w_en  <= w_dec_w;
          r_wb_en     <= w_dec_wb;
          r_s         <= w_dec_s;
          r_b         <= w_dec_b;
          r_xfer_reg  <= w_dec_reg;
          r_xfer_ofs  <= '0;
          if (w_dec_blk) begin
            r_load <= bus.s_in;
            r_rem  <= w_rest;
            if (w_rest != '0) begin
              r_state <= XFER;
              r_cnt   <= OFS_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign bus.exe_cmd   = r_exe_cmd;
  assign bus.mem_r_en  = r_mem_r_en;
  assign bus.mem_w_en  = r_mem_w_en;
  assign bus.wb_en     = r_wb_en;
  assign bus.s         = r_s;
  assign bus.b         = r_b;
  assign bus.valid_out = r_valid_out;
  assign bus.busy      = (r_state == XFER);
  assign bus.xfer_reg  = r_xfer_reg;
  assign bus.xfer_ofs  = r_xfer_ofs;
endmodule
